// File: rtl/gf_const_mult_state.sv
// Lane-wise GF(2^8) constant multiplier, MSB-first Horner, BITS_PER_CYCLE coefficient bits per clock.
// Optional macro GF_CONST_MULT_FASTPATH_EN: coefficients 0x00/0x01/0x02 complete at the accept edge.
//
// state | meaning
// IDLE  | waiting for a request, in_ready=1, out_data holds the last result
// RUN   | Horner steps, BITS_PER_CYCLE coefficient bits per cycle
// DONE  | out_valid=1 with a stable result until out_ready
module gf_const_mult_state #(
    parameter int          NUM_BYTES      = 16,
    parameter logic [7:0]  POLY           = 8'h1B,
    parameter int          BITS_PER_CYCLE = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [8*NUM_BYTES-1:0]   in_data,
    input  logic [7:0]               in_coeff,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [8*NUM_BYTES-1:0]   out_data
);

    localparam int W = 8 * NUM_BYTES;
    localparam int N = 8 / BITS_PER_CYCLE;

    generate
        if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 ||
              BITS_PER_CYCLE == 4 || BITS_PER_CYCLE == 8)) begin : g_bad_bpc
            $error("gf_const_mult_state: BITS_PER_CYCLE must be 1, 2, 4 or 8");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  opnd_q;
    logic [W-1:0]  acc_q;
    logic [W-1:0]  acc_step;
    logic [7:0]    coeff_q;
    logic [3:0]    step_q;
    logic          last_step;
    logic          fast_hit;
    logic [W-1:0]  fast_result;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? POLY : 8'h00);
    endfunction

    assign last_step = (step_q == 4'(N - 1));

`ifdef GF_CONST_MULT_FASTPATH_EN
    assign fast_hit = (in_coeff <= 8'h02);

    always_comb begin
        fast_result = '0;
        for (int i = 0; i < NUM_BYTES; i++) begin
            case (in_coeff)
                8'h01:   fast_result[8*i +: 8] = in_data[8*i +: 8];
                8'h02:   fast_result[8*i +: 8] = xtime(in_data[8*i +: 8]);
                default: fast_result[8*i +: 8] = 8'h00;
            endcase
        end
    end
`else
    assign fast_hit    = 1'b0;
    assign fast_result = '0;
`endif

    // One RUN cycle: BITS_PER_CYCLE Horner steps, consuming coeff_q from its MSB.
    always_comb begin
        logic [7:0] lane;
        acc_step = acc_q;
        for (int b = 0; b < BITS_PER_CYCLE; b++) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                lane = xtime(acc_step[8*i +: 8]);
                if (coeff_q[7-b])
                    lane = lane ^ opnd_q[8*i +: 8];
                acc_step[8*i +: 8] = lane;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = fast_hit ? DONE : RUN;
            RUN:     if (last_step) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            opnd_q   <= '0;
            acc_q    <= '0;
            coeff_q  <= '0;
            step_q   <= '0;
            out_data <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        opnd_q  <= in_data;
                        coeff_q <= in_coeff;
                        acc_q   <= '0;
                        step_q  <= '0;
                        if (fast_hit)
                            out_data <= fast_result;
                    end
                end
                RUN: begin
                    acc_q   <= acc_step;
                    coeff_q <= coeff_q << BITS_PER_CYCLE;
                    step_q  <= step_q + 4'd1;
                    if (last_step)
                        out_data <= acc_step;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gf_const_mult_state.sv
// Bench for gf_const_mult_state: four instances (BITS_PER_CYCLE 1,2,4,8) against a GF(2^8) reference.
module tb_gf_const_mult_state;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    in_valid;
    logic [3:0]    in_ready;
    logic [127:0]  in_data;
    logic [7:0]    in_coeff;
    logic [3:0]    out_valid;
    logic [3:0]    out_ready;
    logic [127:0]  out_data [4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        gf_const_mult_state #(
            .NUM_BYTES(16), .POLY(8'h1B), .BITS_PER_CYCLE(1 << g)
        ) u_dut (
            .clk(clk), .rst(rst),
            .in_valid(in_valid[g]), .in_ready(in_ready[g]),
            .in_data(in_data), .in_coeff(in_coeff),
            .out_valid(out_valid[g]), .out_ready(out_ready[g]),
            .out_data(out_data[g])
        );
    end

    int n_pass = 0;
    int n_total = 0;

    logic          mon_en = 1'b0;
    logic [3:0]    busy;
    logic [127:0]  exp_d [4];
    logic [127:0]  last  [4];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_total++;
        if (act === req)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    endtask

    // Russian-peasant product, LSB-first.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic       hi;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            hi = a[7];
            a  = a << 1;
            if (hi) a = a ^ 8'h1B;
        end
        return p;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] d, input logic [7:0] c);
        logic [127:0] r;
        for (int i = 0; i < 16; i++)
            r[8*i +: 8] = gmul(d[8*i +: 8], c);
        return r;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            for (int k = 0; k < 4; k++) begin
                if (!busy[k]) begin
                    chk("idle_ready", 128'(in_ready[k]), 128'd1);
                    chk("idle_valid", 128'(out_valid[k]), 128'd0);
                    chk("idle_data", out_data[k], last[k]);
                end else begin
                    chk("busy_ready", 128'(in_ready[k]), 128'd0);
                    if (out_valid[k])
                        chk("done_data", out_data[k], exp_d[k]);
                end
            end
        end
    end

    task automatic op(input int k, input logic [127:0] d, input logic [7:0] c,
                      input int hold, output logic [127:0] res);
        int cnt;
        int explat;
        explat = 8 >> k;
`ifdef GF_CONST_MULT_FASTPATH_EN
        if (c <= 8'h02) explat = 0;
`endif
        in_data     = d;
        in_coeff    = c;
        in_valid[k] = 1'b1;
        chk("accept_ready", 128'(in_ready[k]), 128'd1);
        @(posedge clk); #1;
        in_valid[k] = 1'b0;
        busy[k]     = 1'b1;
        exp_d[k]    = model(d, c);
        in_data     = ~d;
        in_coeff    = c ^ 8'h5A;
        cnt = 0;
        while (!out_valid[k] && cnt < 64) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("latency", 128'(cnt), 128'(explat));
        for (int i = 0; i < hold; i++) begin
            in_valid[k] = 1'b1;
            in_data     = d ^ {4{32'h1234_5678}} ^ 128'(i);
            in_coeff    = c + 8'(i + 1);
            @(posedge clk); #1;
        end
        in_valid[k] = 1'b0;
        res = out_data[k];
        chk("result", res, exp_d[k]);
        out_ready[k] = 1'b1;
        @(posedge clk); #1;
        out_ready[k] = 1'b0;
        busy[k]      = 1'b0;
        last[k]      = exp_d[k];
    endtask

    logic [127:0] res;
    logic [127:0] d;
    logic [7:0]   c;
    logic [7:0]   ramp_coeffs [5];

    initial begin
        rst       = 1'b1;
        in_valid  = '0;
        out_ready = '0;
        in_data   = '0;
        in_coeff  = '0;
        busy      = '0;
        for (int k = 0; k < 4; k++) begin
            exp_d[k] = '0;
            last[k]  = '0;
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        mon_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("reset_ready", 128'(in_ready[k]), 128'd1);
            chk("reset_data", out_data[k], 128'd0);
        end

        // Reference pins against FIPS-197 style hand values.
        chk("model_57x13", 128'(gmul(8'h57, 8'h13)), 128'hFE);
        chk("model_57x83", 128'(gmul(8'h57, 8'h83)), 128'hC1);
        chk("model_57x10", 128'(gmul(8'h57, 8'h10)), 128'h07);
        chk("model_57x08", 128'(gmul(8'h57, 8'h08)), 128'h8E);
        chk("model_80x02", 128'(gmul(8'h80, 8'h02)), 128'h1B);

        d = {16{8'h57}};
        op(0, d, 8'h13, 0, res);
        chk("dut_57x13", res, {16{8'hFE}});
        op(0, d, 8'h83, 0, res);
        chk("dut_57x83", res, {16{8'hC1}});
        op(0, d, 8'h10, 0, res);
        chk("dut_57x10", res, {16{8'h07}});
        op(0, d, 8'h08, 0, res);
        chk("dut_57x08", res, {16{8'h8E}});

        for (int i = 0; i < 16; i++) d[8*i +: 8] = 8'(i);
        ramp_coeffs[0] = 8'h02; ramp_coeffs[1] = 8'h0E; ramp_coeffs[2] = 8'h09;
        ramp_coeffs[3] = 8'h0B; ramp_coeffs[4] = 8'h0D;
        for (int j = 0; j < 5; j++) op(0, d, ramp_coeffs[j], 0, res);
        chk("ramp_0d_lane15", 128'(res[127:120]), 128'(gmul(8'h0F, 8'h0D)));

        for (int r = 0; r < 4; r++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            c = 8'($urandom_range(0, 255));
            for (int k = 0; k < 4; k++) op(k, d, c, 0, res);
        end
        for (int k = 0; k < 4; k++) op(k, {16{8'h57}}, 8'h13, 0, res);
        chk("bpc8_57x13", res, {16{8'hFE}});

        // Stalled DONE with ignored requests.
        d = {4{32'hDEAD_BEEF}};
        op(0, d, 8'h0E, 5, res);
        op(2, d, 8'h0B, 5, res);

        // Reset at RUN step 3.
        in_data     = {16{8'hA5}};
        in_coeff    = 8'h37;
        in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        busy[0]     = 1'b1;
        exp_d[0]    = model({16{8'hA5}}, 8'h37);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        busy = '0;
        for (int k = 0; k < 4; k++) last[k] = '0;
        chk("rst_valid", 128'(out_valid[0]), 128'd0);
        chk("rst_data", out_data[0], 128'd0);
        chk("rst_ready", 128'(in_ready[0]), 128'd1);
        op(0, {16{8'h57}}, 8'h13, 0, res);
        chk("post_rst_57x13", res, {16{8'hFE}});

        // Bypass candidates; latency depends on the build.
        op(0, {16{8'h80}}, 8'h02, 0, res);
        chk("80x02", res, {16{8'h1B}});
        op(0, {16{8'h80}}, 8'h00, 0, res);
        chk("80x00", res, 128'd0);
        op(0, {16{8'h80}}, 8'h01, 0, res);
        chk("80x01", res, {16{8'h80}});
        op(0, {16{8'h80}}, 8'h03, 0, res);
        chk("80x03", res, {16{8'h9B}});

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
